// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths and queue entry type for the prefetch unit
package fetch_pkg;
   localparam int INSTR_W = 32;
   localparam int PC_W    = 64;
   localparam logic [PC_W-1:0] PC_INCR = 64'd4;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/prefetch_fifo.sv
// rtl/prefetch_fifo.sv - circular FIFO of fetch entries with flush
module prefetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  fetch_entry_t           push_data,
   output logic [$clog2(DEPTH):0] count,
   output fetch_entry_t           head
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   fetch_entry_t mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   // Flush wins over both push and pop; a push while full is only legal alongside a pop.
   assign do_pop  = pop && !flush && (count != '0);
   assign do_push = push && !flush && ((count != FULL_CNT) || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end
endmodule

// File: rtl/fetch_prefetch_unit.sv
// rtl/fetch_prefetch_unit.sv - credit-limited instruction prefetch queue with redirect flush
module fetch_prefetch_unit
   import fetch_pkg::*;
#(
   parameter int              DEPTH    = 4,
   parameter logic [PC_W-1:0] RESET_PC = 64'h0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               redirect,
   input  logic [PC_W-1:0]    redirect_pc,
   input  logic               deq,
   output logic               valid_out,
   output logic [PC_W-1:0]    pc_out,
   output logic [INSTR_W-1:0] instr_out,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [PC_W-1:0]    imem_req_addr,
   input  logic               imem_resp_valid,
   input  logic [INSTR_W-1:0] imem_resp_data
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [PC_W-1:0] fetch_pc;
   logic [PC_W-1:0] resp_pc;
   logic [CW-1:0]   in_flight;
   logic [CW-1:0]   in_flight_next;
   logic [CW-1:0]   drop_cnt;
   logic [CW-1:0]   count;
   logic [CW:0]     credit_used;
   logic            req_fire;
   logic            resp_ok;
   logic            push;
   logic            pop;
   fetch_entry_t    head;
   fetch_entry_t    push_data;

   // Credits cover queued entries plus outstanding requests, so every response has a slot.
   assign credit_used    = {1'b0, count} + {1'b0, in_flight};
   assign imem_req_valid = credit_used < (CW + 1)'(DEPTH);
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign resp_ok        = imem_resp_valid && (in_flight != '0);
   assign in_flight_next = in_flight + CW'(req_fire) - CW'(resp_ok);
   assign push           = resp_ok && (drop_cnt == '0) && !redirect;
   assign pop            = deq && !redirect;
   assign push_data      = '{pc: resp_pc, instr: imem_resp_data};

   prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .flush     (redirect),
      .push_data (push_data),
      .count     (count),
      .head      (head)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc  <= RESET_PC;
         resp_pc   <= RESET_PC;
         in_flight <= '0;
         drop_cnt  <= '0;
      end else begin
         in_flight <= in_flight_next;
         if (redirect) begin
            // Everything still outstanding, including a request firing now, is old-path.
            fetch_pc <= redirect_pc;
            resp_pc  <= redirect_pc;
            drop_cnt <= in_flight_next;
         end else begin
            if (req_fire) fetch_pc <= fetch_pc + PC_INCR;
            if (push)     resp_pc  <= resp_pc + PC_INCR;
            if (resp_ok && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
         end
      end
   end

   assign valid_out = (count != '0);
   assign pc_out    = valid_out ? head.pc    : '0;
   assign instr_out = valid_out ? head.instr : '0;
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb/tb_fetch_prefetch_unit.sv - vector table, corner sequences and random run against a queue model
module tb_fetch_prefetch_unit;
   localparam int          DEPTH    = 4;
   localparam logic [63:0] RESET_PC = 64'h0;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        redirect = 1'b0;
   logic [63:0] redirect_pc = '0;
   logic        deq = 1'b0;
   logic        imem_req_ready = 1'b0;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = '0;
   logic        valid_out;
   logic [63:0] pc_out;
   logic [31:0] instr_out;
   logic        imem_req_valid;
   logic [63:0] imem_req_addr;

   fetch_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk             (clk),
      .reset           (reset),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc),
      .deq             (deq),
      .valid_out       (valid_out),
      .pc_out          (pc_out),
      .instr_out       (instr_out),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data)
   );

   always #5 clk = ~clk;

   // Outstanding requests (also the memory's pending list) and the expected delivery queue.
   typedef struct { logic [63:0] addr; int due; bit live; } os_t;
   typedef struct { logic [63:0] pc; logic [31:0] instr; } ent_t;
   typedef struct {
      bit rst; bit redir; logic [63:0] rpc; bit dq; bit rdy;
      bit ev; logic [63:0] epc; bit erv; logic [63:0] eaddr;
   } vec_t;

   os_t         os[$];
   ent_t        mq[$];
   logic [63:0] m_fetch;
   int          cyc, last_due, lat;
   int          total, bad;
   vec_t        vt[13];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, exp, cyc);
      end
   endtask

   task automatic drive_resp();
      if (os.size() > 0 && os[0].due <= cyc + 1) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = os[0].addr[31:0];
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = '0;
      end
   endtask

   task automatic tick();
      bit          m_reqv, fire, resp;
      logic [31:0] rdata;
      os_t         e;
      ent_t        n;
      int          d;
      #1;
      m_reqv = (mq.size() + os.size()) < DEPTH;
      if (!reset) begin
         chk("req_valid", imem_req_valid, m_reqv);
         if (m_reqv) chk("req_addr", imem_req_addr, m_fetch);
      end
      fire  = !reset && m_reqv && imem_req_ready;
      resp  = !reset && imem_resp_valid && os.size() > 0;
      rdata = imem_resp_data;
      @(posedge clk);
      cyc++;
      if (reset) begin
         mq.delete();
         os.delete();
         m_fetch  = RESET_PC;
         last_due = cyc;
      end else begin
         if (deq && !redirect && mq.size() > 0) void'(mq.pop_front());
         if (resp) begin
            e = os.pop_front();
            if (e.live && !redirect) begin
               n.pc = e.addr;
               n.instr = rdata;
               mq.push_back(n);
            end
         end
         if (fire) begin
            d = cyc + lat;
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            e.addr = m_fetch; e.due = d; e.live = 1'b1;
            os.push_back(e);
            m_fetch = m_fetch + 64'd4;
         end
         if (redirect) begin
            mq.delete();
            foreach (os[i]) os[i].live = 1'b0;
            m_fetch = redirect_pc;
         end
      end
      #1;
      drive_resp();
      chk("valid_out", valid_out, mq.size() != 0);
      if (mq.size() != 0) begin
         chk("pc_out", pc_out, mq[0].pc);
         chk("instr_out", instr_out, mq[0].instr);
      end else begin
         chk("pc_out_empty", pc_out, 64'h0);
         chk("instr_out_empty", instr_out, 32'h0);
      end
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (!valid_out && n < 30) begin
         tick();
         n++;
      end
      chk(name, valid_out, 1'b1);
   endtask

   task automatic do_reset();
      reset = 1'b1; redirect = 1'b0; deq = 1'b0; imem_req_ready = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      logic [31:0] ei;
      total = 0; bad = 0; cyc = 0; lat = 1; last_due = 0; m_fetch = RESET_PC;

      // rst redir rpc dq rdy | ev epc erv eaddr  (1-cycle memory)
      vt[0]  = '{1, 0, 64'h0,   0, 0, 0, 64'h0,   1, 64'h0};
      vt[1]  = '{0, 0, 64'h0,   1, 1, 0, 64'h0,   1, 64'h4};
      vt[2]  = '{0, 0, 64'h0,   1, 1, 1, 64'h0,   1, 64'h8};
      vt[3]  = '{0, 0, 64'h0,   1, 1, 1, 64'h4,   1, 64'hC};
      vt[4]  = '{0, 0, 64'h0,   1, 1, 1, 64'h8,   1, 64'h10};
      vt[5]  = '{0, 0, 64'h0,   0, 1, 1, 64'h8,   1, 64'h14};
      vt[6]  = '{0, 0, 64'h0,   0, 1, 1, 64'h8,   0, 64'h18};
      vt[7]  = '{0, 0, 64'h0,   0, 1, 1, 64'h8,   0, 64'h18};
      vt[8]  = '{0, 0, 64'h0,   0, 1, 1, 64'h8,   0, 64'h18};
      vt[9]  = '{0, 0, 64'h0,   1, 1, 1, 64'hC,   1, 64'h18};
      vt[10] = '{0, 1, 64'h100, 1, 1, 0, 64'h0,   1, 64'h100};
      vt[11] = '{0, 0, 64'h0,   1, 1, 0, 64'h0,   1, 64'h104};
      vt[12] = '{0, 0, 64'h0,   1, 1, 1, 64'h100, 1, 64'h108};

      repeat (2) @(posedge clk);
      for (int i = 0; i < 13; i++) begin
         reset = vt[i].rst; redirect = vt[i].redir; redirect_pc = vt[i].rpc;
         deq = vt[i].dq; imem_req_ready = vt[i].rdy;
         tick();
         ei = vt[i].ev ? vt[i].epc[31:0] : 32'h0;
         chk("vec_valid_out", valid_out, vt[i].ev);
         chk("vec_pc_out", pc_out, vt[i].epc);
         chk("vec_instr_out", instr_out, ei);
         chk("vec_req_valid", imem_req_valid, vt[i].erv);
         chk("vec_req_addr", imem_req_addr, vt[i].eaddr);
      end
      redirect = 1'b0;

      // 3-cycle memory, three stale requests outstanding at redirect
      do_reset();
      lat = 3; deq = 1'b0; imem_req_ready = 1'b1;
      tick(); tick();
      redirect = 1'b1; redirect_pc = 64'h100;
      tick();
      redirect = 1'b0;
      wait_valid("a_valid_timeout");
      chk("a_first_pc", pc_out, 64'h100);

      // redirect coinciding with a response and a request fire, one in flight
      do_reset();
      lat = 1; deq = 1'b1; imem_req_ready = 1'b1;
      tick();
      redirect = 1'b1; redirect_pc = 64'h100;
      tick();
      redirect = 1'b0;
      chk("b_flushed", valid_out, 1'b0);
      wait_valid("b_valid_timeout");
      chk("b_first_pc", pc_out, 64'h100);

      // memory back-pressure, a spurious response, then reset mid-stream
      do_reset();
      imem_req_ready = 1'b0; deq = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = 32'hdeadbeef;
         end
         tick();
         chk("c_addr_hold", imem_req_addr, RESET_PC);
      end
      imem_req_ready = 1'b1;
      repeat (8) tick();
      reset = 1'b1;
      tick();
      chk("c_rst_valid", valid_out, 1'b0);
      chk("c_rst_pc", pc_out, 64'h0);
      chk("c_rst_instr", instr_out, 32'h0);
      chk("c_rst_addr", imem_req_addr, RESET_PC);
      reset = 1'b0;
      tick();

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         if (i % 250 == 0) lat = 1 + int'($urandom_range(0, 2));
         reset          = ($urandom_range(0, 299) == 0);
         imem_req_ready = ($urandom_range(0, 3) != 0);
         deq            = ($urandom_range(0, 2) != 0);
         redirect       = ($urandom_range(0, 15) == 0);
         redirect_pc    = {$urandom(), $urandom()} & ~64'h3;
         tick();
      end
      reset = 1'b0; redirect = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Instruction-prefetch block directly upstream of the fetch stage and IF/ID register.
- Keeps a small in-order queue of fetched {PC, instruction} pairs filled from a latency-tolerant instruction memory over a valid/ready request channel and a valid-only response channel.
- Supplies the head entry to fetch; absorbs decode stalls via deq; flushes on branch redirect, discarding stale in-flight responses.

Parameters:
DEPTH, 4, queue entries; also the cap on queue count plus in-flight requests (power of 2, min 2)
RESET_PC, 64'h0, first fetch address after reset

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high; clears all state
redirect  input  1  branch taken this cycle; flush and restart at redirect_pc
redirect_pc  input  64  new fetch address, sampled when redirect=1
deq  input  1  consumer accepts head entry (PC enable, i.e. not stalled)
valid_out  output  1  head entry valid
pc_out  output  64  head entry PC
instr_out  output  32  head entry instruction
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  64  fetch address
imem_resp_valid  input  1  response valid; responses return strictly in request order
imem_resp_data  input  32  instruction word

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port named reset.
- State:
  - fetch_pc: next request address.
  - resp_pc: PC of next accepted response.
  - in_flight: accepted requests not yet responded, 0..DEPTH.
  - drop_cnt: in-flight responses to discard.
  - queue: DEPTH entries plus count.
- Reset values: fetch_pc = resp_pc = RESET_PC; in_flight = drop_cnt = count = 0; valid_out = 0; pc_out = 0; instr_out = 0. imem_req_valid may assert in the first cycle after reset deasserts.
- Request issue:
  - imem_req_valid = (count + in_flight < DEPTH).
  - No combinational path from redirect or deq to imem_req_valid.
  - imem_req_addr = fetch_pc.
  - req_fire = valid && ready; on fire, fetch_pc += 4 (64-bit wrap) and in_flight += 1.
- Response, drop_cnt = 0: entry {resp_pc, imem_resp_data} is enqueued and resp_pc += 4. The credit rule guarantees space; enqueue while full is impossible by construction.
- Response, drop_cnt > 0: the response is discarded and drop_cnt -= 1. Either way, in_flight -= 1.
- Response with in_flight = 0: spurious; ignored, no state change.
- Output:
  - valid_out = (count != 0); pc_out and instr_out come from the head entry.
  - The outputs are registered (queue storage), so a response is visible on valid_out the cycle after imem_resp_valid.
  - Output fields are 0 when empty.
- Dequeue:
  - deq && valid_out pops the head.
  - deq when empty is ignored.
  - Enqueue and dequeue in the same cycle leave count unchanged; the queue is never bypassed.
- Redirect (highest priority after reset):
  - count <= 0; any deq in the same cycle is ignored.
  - fetch_pc <= redirect_pc; resp_pc <= redirect_pc.
  - A request firing in the redirect cycle belongs to the old path and is counted as stale.
  - drop_cnt <= in_flight + req_fire − (resp_valid && in_flight != 0); in_flight is updated by the same terms.
  - A response arriving in the redirect cycle is discarded.
  - The first request for redirect_pc is issued the cycle after redirect.
  - Back-to-back redirects: the last one wins; drop_cnt is recomputed each time from in_flight.
- Reset mid-operation: all state returns to reset values; the instruction memory shares reset, so no responses are pending.
- Throughput: with a 1-cycle memory and deq held high, sustains one instruction per cycle once the queue is primed.

Decomposition:
- Shared package fetch_pkg:
  - INSTR_W = 32
  - PC_W = 64
  - PC_INCR = 64'd4
  - typedef fetch_entry_t = packed struct {pc[63:0], instr[31:0]}
- Sub-module prefetch_fifo: synchronous circular FIFO of fetch_entry_t with DEPTH, push, pop, flush, count, head.
  - Flush has priority over push and pop.
  - The credit and drop logic stays in fetch_prefetch_unit.

Test Plan:
- Reset, 1-cycle memory returning addr[31:0] as data, deq=1 → requests 0x0, 0x4, 0x8 on consecutive cycles; valid_out first high 2 cycles after the first request with pc_out=0x0; one entry per cycle thereafter.
- deq=0 for 10 cycles → exactly DEPTH=4 entries accepted, in_flight+count never >4, imem_req_valid=0 when full; deq=1 resumes in order pc 0x0..0xC.
- 3-cycle memory latency, 3 requests in flight, redirect to 0x100 → the 3 stale responses are discarded (drop_cnt 3→0); first valid_out has pc_out=0x100.
- redirect in the same cycle as a response and a request fire with in_flight=1 → drop_cnt=1, count=0; the next response is dropped; the following one is pc 0x100.
- deq and redirect in the same cycle with count=2 → count=0, valid_out=0 next cycle; the next request is for redirect_pc.
- imem_req_ready=0 for 5 cycles, then 1 → imem_req_addr held stable at 0x0; no PC skipped; reset asserted mid-stream → all outputs 0 and next request at RESET_PC.
